// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low keypad one row at a time and debounces whole scan
// frames. It reports one key_valid pulse per accepted press.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
// When the macro is undefined, REPEAT_DELAY and REPEAT_RATE only size the
// shared frame counter and no repeat logic is built.

module keypad_matrix_scanner #(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic       clk100MHZ,
    input  logic       rst,
    output logic [3:0] ROW,
    input  logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int TW    = $clog2(SCAN_DIV);
    localparam int FMAX0 = (DEBOUNCE > REPEAT_DELAY) ? DEBOUNCE : REPEAT_DELAY;
    localparam int FMAX  = (FMAX0 > REPEAT_RATE) ? FMAX0 : REPEAT_RATE;
    localparam int FW    = $clog2(FMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] DEB_N     = FW'(DEBOUNCE);
    localparam logic [FW-1:0] FRAME_MAX = FW'(FMAX);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [FW-1:0] DELAY_N   = FW'(REPEAT_DELAY);
    localparam logic [FW-1:0] RATE_N    = FW'(REPEAT_RATE);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    row_idx;
    logic [15:0]   samples;
    logic          tick;
    logic          frame_done;

    logic [15:0]   frame_now;
    logic [15:0]   low;
    logic          frame_none;
    logic          frame_single;
    logic [3:0]    frame_code;

    state_t        state;
    state_t        state_n;
    logic [FW-1:0] cnt;
    logic [FW-1:0] cnt_n;
    logic [FW-1:0] cnt_inc;
    logic [3:0]    cand;
    logic [3:0]    cand_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          down_n;
`ifdef KEYPAD_REPEAT_EN
    logic          rep_first;
    logic          rep_first_n;
`endif

    assign tick       = (tick_cnt == TICK_LAST);
    assign frame_done = tick && (row_idx == 2'd3);
    assign ROW        = ~(4'b0001 << row_idx);
    assign cnt_inc    = (cnt == FRAME_MAX) ? cnt : cnt + FW'(1);

    // Synchronize COL, run the row-step timer and latch each row's columns at the end of its window
    always_ff @(posedge clk100MHZ) begin
        if (rst) begin
            col_s1   <= '0;
            col_s2   <= '0;
            tick_cnt <= '0;
            row_idx  <= 2'd0;
            samples  <= 16'hFFFF;
        end else begin
            col_s1   <= COL;
            col_s2   <= col_s1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                samples[{row_idx, 2'b00} +: 4] <= col_s2;
                row_idx <= row_idx + 2'd1;
            end
        end
    end

    // Classify the frame, merging in the row being sampled on this tick
    always_comb begin
        frame_now = samples;
        frame_now[{row_idx, 2'b00} +: 4] = col_s2;
        low          = ~frame_now;
        frame_none   = (low == 16'h0000);
        frame_single = !frame_none && ((low & (low - 16'd1)) == 16'h0000);
        frame_code   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (low[i]) begin
                frame_code = 4'(i);
            end
        end
    end

    // Debounce state register and registered key outputs
    always_ff @(posedge clk100MHZ) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_first <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
`ifdef KEYPAD_REPEAT_EN
            rep_first <= rep_first_n;
`endif
        end
    end

    // Next-state logic, advanced only when a full frame has been classified
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
`ifdef KEYPAD_REPEAT_EN
        rep_first_n = rep_first;
`endif
        if (frame_done) begin
            case (state)
                ST_IDLE: begin
                    if (frame_single) begin
                        if (DEBOUNCE == 1) begin
                            state_n = ST_PRESSED;
                            code_n  = frame_code;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_first_n = 1'b0;
`endif
                        end else begin
                            state_n = ST_DEBOUNCE;
                            cand_n  = frame_code;
                            cnt_n   = FW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_single && (frame_code == cand)) begin
                        if (cnt_inc >= DEB_N) begin
                            state_n = ST_PRESSED;
                            code_n  = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_first_n = 1'b0;
`endif
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (frame_single) begin
                        cand_n = frame_code;
                        cnt_n  = FW'(1);
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_none) begin
                        if (DEBOUNCE == 1) begin
                            state_n = ST_IDLE;
                            down_n  = 1'b0;
                            cnt_n   = '0;
                        end else begin
                            state_n = ST_RELEASE;
                            cnt_n   = FW'(1);
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (cnt_inc >= (rep_first ? RATE_N : DELAY_N)) begin
                            valid_n     = 1'b1;
                            cnt_n       = '0;
                            rep_first_n = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (frame_none) begin
                        if (cnt_inc >= DEB_N) begin
                            state_n = ST_IDLE;
                            down_n  = 1'b0;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = ST_PRESSED;
                        cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_first_n = 1'b0;
`endif
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule
